// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes an identity-initialised 256-byte S RAM
// in place using a 24-bit key, one single-port RAM access per cycle.
module ksa (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  s_addr,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);

    typedef enum logic [2:0] {
        IDLE,
        READ_I,
        STALL_I,
        CALC_J,
        READ_J,
        STALL_J,
        WRITE_I,
        WRITE_J
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;
    logic [23:0] key_q, key_d;
    logic [1:0]  ksel_q, ksel_d;
    logic        rdy_q, rdy_d;
    logic [7:0]  kb;

    // ksel tracks i mod 3 alongside i, avoiding a divider on the i counter.
    always_comb begin
        case (ksel_q)
            2'd0:    kb = key_q[23:16];
            2'd1:    kb = key_q[15:8];
            default: kb = key_q[7:0];
        endcase
    end

    always_comb begin
        // NOTE: every output and next-state signal is defaulted first so no
        // path through the case statement can leave one unassigned (no latches).
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        si_d     = si_q;
        sj_d     = sj_q;
        key_d    = key_q;
        ksel_d   = ksel_q;
        rdy_d    = rdy_q;
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;

        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (en && rdy_q) begin
                    state_d = READ_I;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    ksel_d  = 2'd0;
                    key_d   = key;
                    rdy_d   = 1'b0;
                end
            end
            READ_I: begin
                s_addr  = i_q;
                state_d = STALL_I;
            end
            STALL_I: begin
                s_addr  = i_q;
                si_d    = s_rddata;
                state_d = CALC_J;
            end
            CALC_J: begin
                s_addr  = i_q;
                j_d     = j_q + si_q + kb;
                state_d = READ_J;
            end
            READ_J: begin
                s_addr  = j_q;
                state_d = STALL_J;
            end
            STALL_J: begin
                s_addr  = j_q;
                sj_d    = s_rddata;
                state_d = WRITE_I;
            end
            WRITE_I: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
                state_d  = WRITE_J;
            end
            WRITE_J: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                if (i_q == 8'd255) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = READ_I;
                    i_d     = i_q + 8'd1;
                    ksel_d  = (ksel_q == 2'd2) ? 2'd0 : ksel_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            key_q   <= 24'd0;
            ksel_q  <= 2'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
            ksel_q  <= ksel_d;
            rdy_q   <= rdy_d;
        end
    end

    assign rdy = rdy_q;

endmodule

// File: doc/ksa.md
# ksa

RC4 key-scheduling stage. Permutes a 256-byte S memory that already holds the identity table (s[i]=i) using a 24-bit key. The permuted S is the direct input to the pseudo-random generation stage (prga). Talks to a single-port synchronous S RAM and uses the same en/rdy handshake as its neighbours.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state changes on posedge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  start request; sampled only while rdy=1
- rdy  output  1  block idle and able to accept en
- key  input  24  RC4 key; latched on the accepted en edge
- s_addr  output  8  S RAM address
- s_rddata  input  8  S RAM read data
- s_wrdata  output  8  S RAM write data
- s_wren  output  1  S RAM write enable

## Operation
- Algorithm: j=0; for i=0..255 { j=(j+s[i]+kb(i)) mod 256; swap s[i], s[j] }.
- Key byte selection, by i mod 3:
  - 0: kb=key[23:16]
  - 1: kb=key[15:8]
  - 2: kb=key[7:0]
- Internal registers:
  - i, j: 8 bits each; all additions wrap mod 256.
  - si, sj: 8 bits each.
  - key_q: 24 bits.
- RAM model: the address is sampled on a posedge. The matching s_rddata is valid through the following cycle and is sampled on the next posedge. Writes commit on the posedge ending a cycle with s_wren=1.
- States and outputs (Moore; no combinational path from inputs to outputs):
  - IDLE: s_addr=0, s_wrdata=0, s_wren=0.
  - READ_I: s_addr=i.
  - STALL_I: s_addr=i; si<=s_rddata at exit.
  - CALC_J: s_addr=i; j<=j+si+kb(i).
  - READ_J: s_addr=j.
  - STALL_J: s_addr=j; sj<=s_rddata at exit.
  - WRITE_I: s_addr=i, s_wrdata=sj, s_wren=1.
  - WRITE_J: s_addr=j, s_wrdata=si, s_wren=1.
  - In every state other than WRITE_I and WRITE_J: s_wrdata=0, s_wren=0.
- Transitions:
  - IDLE→READ_I on en&rdy. On that edge: i<=0, j<=0, key_q<=key, rdy<=0.
  - READ_I→STALL_I→CALC_J→READ_J→STALL_J→WRITE_I→WRITE_J, unconditionally.
  - WRITE_J→READ_I with i<=i+1 if i≠255.
  - WRITE_J→IDLE with rdy<=1 if i==255. Termination is detected by comparing i to 255, not by counter overflow.
- i==j: both writes store the same value (si==sj), leaving S unchanged at that index. This is legal behaviour, not an error.
- en while rdy=0: ignored, no effect.
- key changes after acceptance: no effect (key_q is used).

## Timing
- Reset values: state=IDLE, rdy=0, s_addr=0, s_wrdata=0, s_wren=0, i=0, j=0, si=0, sj=0, key_q=0.
- rdy rises on the first posedge after rst_n deasserts. It stays 1 in IDLE until en is accepted.
- Iteration length: 7 cycles. Full run: 256×7=1792 cycles.
- Latency: en accepted at edge E0. The first READ_I cycle follows E0. rdy=1 is visible after edge E0+1792.
- Back-to-back: en held high at completion is accepted on the next edge (E0+1793), starting a new run immediately.
- rst_n low mid-run: state returns to IDLE and s_wren goes to 0 asynchronously. S is left partially permuted; no cleanup is performed. The next accepted en restarts at i=0, j=0.
- Exactly one RAM access per cycle. There are never two write cycles without a full read sequence between them, except the WRITE_I/WRITE_J pair.

## Test plan
- Reset/handshake: rst_n=0 then 1 → after first posedge, rdy=1, s_wren=0, s_addr=0. Then en=1 for one cycle → rdy=0 on next edge, state READ_I, s_addr=0.
- First swaps: S=identity, key=24'h010203.
  - Iteration 0: WRITE_I addr 0 data 01, WRITE_J addr 1 data 00.
  - Iteration 1: j=03; WRITE_I addr 1 data 03, WRITE_J addr 3 data 00.
- Full run vs golden model: key=24'h1E4600 and key=24'h000018 with a behavioural RAM → final S equals the software RC4 KSA byte-for-byte, and rdy rises exactly 1792 cycles after en acceptance.
- i==j path: S=identity, key=24'h000000 → iteration 0 writes addr 0 data 00 twice, and S[0] is unchanged.
- en ignored while busy and key latched: pulse en and change key to 24'hFFFFFF at cycle 100 of a run → no restart, and the final S matches the originally latched key.
- Mid-run reset: assert rst_n=0 at cycle 500 → s_wren=0 immediately and rdy=0. After release, rdy=1. A new en produces correct S when the bench reloads the identity table first.
